// File: rtl/bpu_pkg.sv
// ============================================================================
// Module      : bpu_pkg
// Description : Shared types, counter encodings and saturating counter helpers
//               for the branch prediction unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bpu_pkg;

   // Entry fields are stored at the widest legal PC width; narrower
   // configurations keep the upper bits at zero.
   localparam int BPU_FIELD_W = 32;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'd0;
   localparam ctr_t CTR_WNT = 2'd1;
   localparam ctr_t CTR_WT  = 2'd2;
   localparam ctr_t CTR_ST  = 2'd3;

   typedef struct packed {
      logic                   valid;
      logic [BPU_FIELD_W-1:0] tag;
      logic [BPU_FIELD_W-1:0] target;
      ctr_t                   ctr;
   } bpu_entry_t;

   localparam bpu_entry_t BPU_ENTRY_RESET = '{
      valid  : 1'b0,
      tag    : '0,
      target : '0,
      ctr    : CTR_WNT
   };

   function automatic ctr_t ctr_inc(input ctr_t c);
      return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
   endfunction

   function automatic ctr_t ctr_dec(input ctr_t c);
      return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_table.sv
// ============================================================================
// Module      : bpu_table
// Description : Predictor entry array with one combinational read port and one
//               synchronous read-modify-write update port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpu_table
   import bpu_pkg::*;
#(
   parameter  int PC_W    = 9,
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES),
   localparam int TAG_W   = PC_W - IDX_W - 2
) (
   input  logic             clk,
   input  logic             reset,
   // lookup port
   input  logic [IDX_W-1:0] rd_idx,
   output bpu_entry_t       rd_entry,
   // update port
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [PC_W-1:0]  wr_target,
   input  logic             wr_taken,
   input  logic             wr_uncond
);

   bpu_entry_t r_mem [ENTRIES];

   bpu_entry_t w_cur;
   bpu_entry_t w_next;
   logic       w_hit;
   logic       w_write;

   assign rd_entry = r_mem[rd_idx];

   assign w_cur = r_mem[wr_idx];
   assign w_hit = w_cur.valid && (w_cur.tag == BPU_FIELD_W'(wr_tag));

   // Taken outcomes either train a hitting entry or allocate over the slot;
   // a not-taken outcome only weakens an entry that already owns this PC.
   always_comb begin
      w_next  = w_cur;
      w_write = 1'b0;
      if (wr_taken) begin
         w_write       = 1'b1;
         w_next.valid  = 1'b1;
         w_next.tag    = BPU_FIELD_W'(wr_tag);
         w_next.target = BPU_FIELD_W'(wr_target);
         if (wr_uncond) begin
            w_next.ctr = CTR_ST;
         end else if (w_hit) begin
            w_next.ctr = ctr_inc(w_cur.ctr);
         end else begin
            w_next.ctr = CTR_WT;
         end
      end else if (w_hit) begin
         w_write    = 1'b1;
         w_next.ctr = ctr_dec(w_cur.ctr);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_mem[i] <= BPU_ENTRY_RESET;
         end
      end else if (wr_en && w_write) begin
         r_mem[wr_idx] <= w_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module      : branch_predict_unit
// Description : Tagged 2-bit branch predictor with EX-stage resolution, flush
//               and redirect generation.
//               Optional event counters enabled by defining BPU_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int PC_W    = 9,
   parameter int ENTRIES = 16
) (
   input  logic            clk,
   input  logic            reset,
   // fetch lookup
   input  logic [PC_W-1:0] if_pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   // execute resolution
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jal,
   input  logic            ex_jalr,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [31:0]     ex_imm,
   input  logic [31:0]     ex_rs1,
   input  logic            ex_cmp,
   input  logic            ex_pred_taken,
   input  logic [PC_W-1:0] ex_pred_target,
   output logic            flush,
   output logic [31:0]     redirect_pc,
   output logic [31:0]     link_pc,
   // event counters
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   if ((ENTRIES < 2) || ((1 << IDX_W) != ENTRIES) || (PC_W < IDX_W + 3) || (PC_W > 32))
   begin : g_param_check
      $error("branch_predict_unit: illegal PC_W/ENTRIES combination");
   end

   bpu_entry_t      w_rd_entry;
   logic            w_hit;
   logic            w_unused_target;
   logic [PC_W-1:0] w_if_pc_plus4;
   logic            w_actual_taken;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_ex_pc_plus4;
   logic            w_flush;
   logic            w_update;

   // ---------------------------------------------------------------- lookup
   assign w_if_pc_plus4 = if_pc + PC_W'(4);
   assign w_hit         = w_rd_entry.valid &&
                          (w_rd_entry.tag == BPU_FIELD_W'(if_pc[PC_W-1:IDX_W+2]));
   assign pred_taken    = w_hit && w_rd_entry.ctr[1];
   assign pred_target   = w_hit ? w_rd_entry.target[PC_W-1:0] : w_if_pc_plus4;

   // Target bits above PC_W are zero-extension and carry no information.
   assign w_unused_target = ^w_rd_entry.target;

   // ------------------------------------------------------------ resolution
   assign w_actual_taken = ex_jal || ex_jalr || (ex_branch && ex_cmp);
   assign w_target       = ex_jalr ? PC_W'((ex_rs1 + ex_imm) & ~32'd1)
                                   : PC_W'(32'(ex_pc) + ex_imm);
   assign w_ex_pc_plus4  = ex_pc + PC_W'(4);

   assign w_flush = ex_valid &&
                    ((w_actual_taken != ex_pred_taken) ||
                     (w_actual_taken && (w_target != ex_pred_target)));

   assign flush       = w_flush;
   assign redirect_pc = w_flush ? 32'(w_actual_taken ? w_target : w_ex_pc_plus4) : 32'd0;
   assign link_pc     = 32'(w_ex_pc_plus4);

   assign w_update = ex_valid && (ex_branch || ex_jal || ex_jalr);

   // Read and update ports are independent; a same-index lookup sees the
   // pre-update entry until the following cycle.
   bpu_table #(
      .PC_W    (PC_W),
      .ENTRIES (ENTRIES)
   ) u_table (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (if_pc[IDX_W+1:2]),
      .rd_entry  (w_rd_entry),
      .wr_en     (w_update),
      .wr_idx    (ex_pc[IDX_W+1:2]),
      .wr_tag    (ex_pc[PC_W-1:IDX_W+2]),
      .wr_target (w_target),
      .wr_taken  (w_actual_taken),
      .wr_uncond (ex_jal || ex_jalr)
   );

   // ---------------------------------------------------------- perf events
`ifdef BPU_PERF_EN
   logic [31:0] r_perf_branches;
   logic [31:0] r_perf_mispredicts;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_branches    <= 32'd0;
         r_perf_mispredicts <= 32'd0;
      end else begin
         if (w_update) begin
            r_perf_branches <= r_perf_branches + 32'd1;
         end
         if (w_flush) begin
            r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
         end
      end
   end

   assign perf_branches    = r_perf_branches;
   assign perf_mispredicts = r_perf_mispredicts;
`else
   assign perf_branches    = 32'd0;
   assign perf_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit: directed vector
//               table, reset sequence and randomized traffic vs. a model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

   localparam int PC_W    = 9;
   localparam int ENTRIES = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [PC_W-1:0] if_pc;
   logic            pred_taken;
   logic [PC_W-1:0] pred_target;
   logic            ex_valid, ex_branch, ex_jal, ex_jalr;
   logic [PC_W-1:0] ex_pc;
   logic [31:0]     ex_imm, ex_rs1;
   logic            ex_cmp, ex_pred_taken;
   logic [PC_W-1:0] ex_pred_target;
   logic            flush;
   logic [31:0]     redirect_pc, link_pc, perf_branches, perf_mispredicts;

   always #5 clk = ~clk;

   branch_predict_unit #(.PC_W(PC_W), .ENTRIES(ENTRIES)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .ex_valid(ex_valid), .ex_branch(ex_branch),
      .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_cmp(ex_cmp), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .flush(flush), .redirect_pc(redirect_pc),
      .link_pc(link_pc), .perf_branches(perf_branches),
      .perf_mispredicts(perf_mispredicts)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   bit          m_valid [ENTRIES];
   int          m_tag   [ENTRIES];
   logic [8:0]  m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int          m_br, m_mis;

   logic        x_pt, x_taken, x_flush;
   logic [8:0]  x_ptgt, x_tgt;
   logic [31:0] x_redir, x_link;

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 9'h0; m_ctr[i] = 1;
      end
      m_br = 0; m_mis = 0;
   endfunction

   function automatic void model_lookup(input logic [8:0] pc, output logic pt,
                                        output logic [8:0] tgt, output logic hit);
      int idx, tag;
      idx = (int'(pc) / 4) % ENTRIES;
      tag = int'(pc) / (4 * ENTRIES);
      hit = m_valid[idx] && (m_tag[idx] == tag);
      pt  = hit && (m_ctr[idx] >= 2);
      tgt = hit ? m_tgt[idx] : 9'((int'(pc) + 4) % 512);
   endfunction

   function automatic void model_expect();
      logic        hit;
      logic [31:0] t32;
      model_lookup(if_pc, x_pt, x_ptgt, hit);
      x_taken = ex_jal || ex_jalr || (ex_branch && ex_cmp);
      t32     = ex_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : ({23'd0, ex_pc} + ex_imm);
      x_tgt   = t32[8:0];
      x_flush = ex_valid && ((x_taken != ex_pred_taken) || (x_taken && (x_tgt != ex_pred_target)));
      x_link  = 32'((int'(ex_pc) + 4) % 512);
      x_redir = !x_flush ? 32'd0 : (x_taken ? {23'd0, x_tgt} : x_link);
   endfunction

   function automatic void model_commit();
      int idx, tag, nc;
      logic hit, pt;
      logic [8:0] tg;
      if (reset) begin
         model_reset();
         return;
      end
      if (x_flush) m_mis++;
      if (ex_valid && (ex_branch || ex_jal || ex_jalr)) begin
         m_br++;
         idx = (int'(ex_pc) / 4) % ENTRIES;
         tag = int'(ex_pc) / (4 * ENTRIES);
         model_lookup(ex_pc, pt, tg, hit);
         if (x_taken) begin
            if (ex_jal || ex_jalr) nc = 3;
            else if (hit)          nc = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            else                   nc = 2;
            m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = x_tgt; m_ctr[idx] = nc;
         end else if (hit) begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
         end
      end
   endfunction

   task automatic check_perf(input string name);
`ifdef BPU_PERF_EN
      chk({name, " perf_branches"},    perf_branches,    32'(m_br));
      chk({name, " perf_mispredicts"}, perf_mispredicts, 32'(m_mis));
`else
      chk({name, " perf_branches"},    perf_branches,    32'd0);
      chk({name, " perf_mispredicts"}, perf_mispredicts, 32'd0);
`endif
   endtask

   task automatic check_model(input string name);
      model_expect();
      chk({name, " pred_taken"},  32'(pred_taken),  32'(x_pt));
      chk({name, " pred_target"}, 32'(pred_target), 32'(x_ptgt));
      chk({name, " flush"},       32'(flush),       32'(x_flush));
      chk({name, " redirect_pc"}, redirect_pc,      x_redir);
      chk({name, " link_pc"},     link_pc,          x_link);
      check_perf(name);
   endtask

   task automatic next_cycle();
      model_expect();
      model_commit();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [8:0] pick_pc();
      return {3'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
   endfunction

   // ---------------------------------------------------------- vector table
   typedef struct {
      logic [8:0]  ifp;
      logic [3:0]  ctl;      // {ex_valid, ex_branch, ex_jal, ex_jalr}
      logic [8:0]  pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        cmp;
      logic        pt;
      logic [8:0]  ptgt;
      logic        e_pt;
      logic [8:0]  e_ptgt;
      logic        e_flush;
      logic [31:0] e_redir;
      logic [31:0] e_link;
   } vec_t;

   vec_t tbl [21];

   initial begin
      tbl[0]  = '{9'h040, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h000, 32'h004};
      tbl[1]  = '{9'h040, 4'b1100, 9'h040, 32'h020, 32'h000, 1'b1, 1'b0, 9'h044, 1'b0, 9'h044, 1'b1, 32'h060, 32'h044};
      tbl[2]  = '{9'h040, 4'b1100, 9'h040, 32'h020, 32'h000, 1'b0, 1'b1, 9'h060, 1'b1, 9'h060, 1'b1, 32'h044, 32'h044};
      tbl[3]  = '{9'h040, 4'b1100, 9'h040, 32'h020, 32'h000, 1'b0, 1'b0, 9'h044, 1'b0, 9'h060, 1'b0, 32'h000, 32'h044};
      tbl[4]  = '{9'h040, 4'b0100, 9'h040, 32'h020, 32'h000, 1'b1, 1'b0, 9'h044, 1'b0, 9'h060, 1'b0, 32'h000, 32'h044};
      tbl[5]  = '{9'h040, 4'b1000, 9'h0C0, 32'h000, 32'h000, 1'b0, 1'b1, 9'h100, 1'b0, 9'h060, 1'b1, 32'h0C4, 32'h0C4};
      tbl[6]  = '{9'h080, 4'b1001, 9'h080, 32'h010, 32'h101, 1'b0, 1'b0, 9'h084, 1'b0, 9'h084, 1'b1, 32'h110, 32'h084};
      tbl[7]  = '{9'h080, 4'b1001, 9'h080, 32'h010, 32'h101, 1'b0, 1'b1, 9'h110, 1'b1, 9'h110, 1'b0, 32'h000, 32'h084};
      tbl[8]  = '{9'h040, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h000, 32'h004};
      tbl[9]  = '{9'h040, 4'b1100, 9'h040, 32'h020, 32'h000, 1'b1, 1'b0, 9'h044, 1'b0, 9'h044, 1'b1, 32'h060, 32'h044};
      tbl[10] = '{9'h040, 4'b1100, 9'h140, 32'h020, 32'h000, 1'b1, 1'b0, 9'h144, 1'b1, 9'h060, 1'b1, 32'h160, 32'h144};
      tbl[11] = '{9'h040, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h000, 32'h004};
      tbl[12] = '{9'h140, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b1, 9'h160, 1'b0, 32'h000, 32'h004};
      tbl[13] = '{9'h100, 4'b1010, 9'h100, 32'h1F0, 32'h000, 1'b0, 1'b0, 9'h104, 1'b0, 9'h104, 1'b1, 32'h0F0, 32'h104};
      tbl[14] = '{9'h100, 4'b1100, 9'h100, 32'h1F0, 32'h000, 1'b0, 1'b1, 9'h0F0, 1'b1, 9'h0F0, 1'b1, 32'h104, 32'h104};
      tbl[15] = '{9'h100, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b1, 9'h0F0, 1'b0, 32'h000, 32'h004};
      tbl[16] = '{9'h1FC, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 32'h004};
      tbl[17] = '{9'h100, 4'b1100, 9'h100, 32'h1F0, 32'h000, 1'b1, 1'b1, 9'h0F0, 1'b1, 9'h0F0, 1'b0, 32'h000, 32'h104};
      tbl[18] = '{9'h100, 4'b1100, 9'h100, 32'h1F0, 32'h000, 1'b1, 1'b1, 9'h0F0, 1'b1, 9'h0F0, 1'b0, 32'h000, 32'h104};
      tbl[19] = '{9'h100, 4'b1100, 9'h100, 32'h1F0, 32'h000, 1'b0, 1'b1, 9'h0F0, 1'b1, 9'h0F0, 1'b1, 32'h104, 32'h104};
      tbl[20] = '{9'h100, 4'b0000, 9'h000, 32'h000, 32'h000, 1'b0, 1'b0, 9'h000, 1'b1, 9'h0F0, 1'b0, 32'h000, 32'h004};
   end

   // -------------------------------------------------------------- sequence
   initial begin
      reset = 1'b1; if_pc = '0;
      ex_valid = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
      ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_cmp = 1'b0;
      ex_pred_taken = 1'b0; ex_pred_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_perf("after reset");

      // directed vectors, applied in order from the reset state
      foreach (tbl[i]) begin
         if_pc = tbl[i].ifp;
         {ex_valid, ex_branch, ex_jal, ex_jalr} = tbl[i].ctl;
         ex_pc = tbl[i].pc; ex_imm = tbl[i].imm; ex_rs1 = tbl[i].rs1;
         ex_cmp = tbl[i].cmp; ex_pred_taken = tbl[i].pt; ex_pred_target = tbl[i].ptgt;
         #1;
         chk($sformatf("row%0d pred_taken", i),  32'(pred_taken),  32'(tbl[i].e_pt));
         chk($sformatf("row%0d pred_target", i), 32'(pred_target), 32'(tbl[i].e_ptgt));
         chk($sformatf("row%0d flush", i),       32'(flush),       32'(tbl[i].e_flush));
         chk($sformatf("row%0d redirect_pc", i), redirect_pc,      tbl[i].e_redir);
         chk($sformatf("row%0d link_pc", i),     link_pc,          tbl[i].e_link);
         next_cycle();
      end
      check_perf("after table");

      // reset in the same cycle as a taken JAL: the update must be dropped
      reset = 1'b1; if_pc = 9'h1FC;
      {ex_valid, ex_branch, ex_jal, ex_jalr} = 4'b1010;
      ex_pc = 9'h1FC; ex_imm = 32'h40; ex_cmp = 1'b0;
      ex_pred_taken = 1'b0; ex_pred_target = 9'h000;
      #1;
      chk("reset-cycle flush",    32'(flush), 32'd1);
      chk("reset-cycle redirect", redirect_pc, 32'h03C);
      next_cycle();
      reset = 1'b0; ex_valid = 1'b0; ex_jal = 1'b0;
      #1;
      chk("post-reset 0x1FC pred_taken",  32'(pred_taken),  32'd0);
      chk("post-reset 0x1FC pred_target", 32'(pred_target), 32'h000);
      check_perf("post-reset");
      next_cycle();
      if_pc = 9'h100;
      #1;
      chk("post-reset 0x100 pred_taken",  32'(pred_taken),  32'd0);
      chk("post-reset 0x100 pred_target", 32'(pred_target), 32'h104);
      next_cycle();

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         int k;
         logic       mpt, mhit;
         logic [8:0] mtg;
         reset    = ($urandom_range(0, 149) == 0);
         if_pc    = pick_pc();
         ex_valid = ($urandom_range(0, 3) != 0);
         k        = $urandom_range(0, 4);
         ex_branch = (k == 1) || (k == 4);
         ex_jal    = (k == 2);
         ex_jalr   = (k == 3);
         ex_pc    = pick_pc();
         ex_imm   = 32'($urandom_range(0, 1023)) - 32'd512;
         ex_rs1   = $urandom;
         ex_cmp   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            model_lookup(ex_pc, mpt, mtg, mhit);
            ex_pred_taken = mpt; ex_pred_target = mtg;
         end else begin
            ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = pick_pc();
         end
         #1;
         check_model($sformatf("rand%0d", n));
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
